// File: rtl/mssd_param_demux.sv
// Parametrised serial frame demux: start, LSB-first header (port, length), payload, stop.
// Optional even parity bit before the stop bit when MSSD_PARITY_EN is defined.
module mssd_param_demux #(
  parameter int PN_W  = 2,
  parameter int LEN_W = 6,
  parameter int UNIT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SerIn,
  output logic [2**PN_W-1:0]   p,
  output logic [PN_W-1:0]      pn,
  output logic [LEN_W-1:0]     len,
  output logic                 outValid,
  output logic                 pkt_done,
  output logic                 error,
  output logic                 parity_err
);

  localparam int HW  = PN_W + LEN_W;
  localparam int HCW = $clog2(HW + 1);
  localparam int BCW = LEN_W + $clog2(UNIT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_PAR,
    S_STOP,
    S_ERR
  } state_t;

  state_t state, nxt;

  logic [HCW-1:0]   hcnt;
  logic [HW-2:0]    sh;
  logic [HW-1:0]    hdr_full;
  logic [LEN_W-1:0] hdr_len;
  logic [BCW-1:0]   bcnt;
  logic             hdr_last;
  logic             data_last;
  state_t           after_pay;

  assign hdr_full  = {SerIn, sh};
  assign hdr_len   = hdr_full[HW-1:PN_W];
  assign hdr_last  = (state == S_HDR) && (hcnt == HCW'(HW - 1));
  assign data_last = (bcnt == BCW'(1));

`ifdef MSSD_PARITY_EN
  assign after_pay = S_PAR;
  logic par;
  logic par_bad;
  assign par_bad = par ^ SerIn;
`else
  assign after_pay = S_STOP;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (!SerIn) nxt = S_HDR;
      S_HDR: begin
        if (hdr_last) begin
          if (hdr_len == '0) nxt = after_pay;
          else               nxt = S_DATA;
        end
      end
      S_DATA: if (data_last) nxt = after_pay;
`ifdef MSSD_PARITY_EN
      S_PAR:  nxt = par_bad ? S_ERR : S_STOP;
`else
      S_PAR:  nxt = S_IDLE;
`endif
      S_STOP: nxt = SerIn ? S_IDLE : S_ERR;
      S_ERR:  if (SerIn) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    outValid = 1'b0;
    error    = 1'b0;
    p        = '0;
    if (state == S_DATA) begin
      outValid = 1'b1;
      p[pn]    = SerIn;
    end
    if (state == S_ERR) error = 1'b1;
  end

  // Header shift, payload counter and held header fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt     <= '0;
      sh       <= '0;
      bcnt     <= '0;
      pn       <= '0;
      len      <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= (state == S_STOP) && SerIn;
      if (state == S_HDR) begin
        hcnt <= hcnt + 1'b1;
        sh   <= hdr_full[HW-1:1];
      end else begin
        hcnt <= '0;
      end
      if (hdr_last) begin
        pn   <= hdr_full[PN_W-1:0];
        len  <= hdr_len;
        bcnt <= BCW'(hdr_len) * BCW'(UNIT);
      end else if (state == S_DATA) begin
        bcnt <= bcnt - 1'b1;
      end
    end
  end

`ifdef MSSD_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par        <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= (state == S_PAR) && par_bad;
      if (hdr_last)              par <= 1'b0;
      else if (state == S_DATA)  par <= par ^ SerIn;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
